mem_loader: RTL and testbench
=============================

// Module: mem_loader
// PURPOSE
//  Boot-time program loader sitting directly upstream of the multicycle CPU.
//  - Streams 32-bit instruction/data words over a valid/ready port into the unified data memory.
//  - Holds the CPU stalled until the image is complete, then releases it.
//  - Top level muxes the memory address/din/we between loader (cpu_run=0) and CPU (cpu_run=1).
// PARAMETERS
//  MEM_WORDS  1024  memory depth in words; the load image must fit in [BASE_ADDR, BASE_ADDR+MEM_WORDS)
//  BASE_ADDR  0     word address of the first loaded word; the PC is expected to start here
//  ADDR_STEP  1     address increment per word (memory is word-addressed, PC steps by 1)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  start      in   1   1-cycle pulse; begins a load, honoured only in IDLE
//  in_valid   in   1   in_data/in_last valid
//  in_ready   out  1   loader accepts a word this cycle
//  in_data    in   32  word to write
//  in_last    in   1   marks final word of the image
//  mem_addr   out  32  memory word address (registered)
//  mem_din    out  32  memory write data (registered)
//  mem_we     out  1   memory write enable (registered, 1-cycle pulse per word)
//  cpu_run    out  1   1 = CPU owns memory and PC/IR write enables are permitted
//  done       out  1   image loaded OK (level, held in RUN)
//  error      out  1   image overflowed MEM_WORDS (level, held in ERROR)
//  word_count out  11  words accepted so far ($clog2(MEM_WORDS)+1 bits)
//  checksum   out  32  mod-2^32 sum of accepted words
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_din=0,
//    cpu_run=0, done=0, error=0, word_count=0, checksum=0. Memory contents are untouched.
//  States: IDLE -> LOAD -> DRAIN -> RUN; LOAD -> ERROR. RUN and ERROR exit only by reset.
//  IDLE:  in_ready=0. start=1 -> LOAD; word_count, checksum cleared.
//  LOAD:  in_ready=1 (combinational from state only, never from in_valid).
//    Accept = in_valid & in_ready. On accept in cycle N:
//    - cycle N+1: mem_we=1, mem_addr=BASE_ADDR+word_count(N)*ADDR_STEP, mem_din=in_data(N).
//    - word_count+=1; checksum+=in_data (wraps mod 2^32).
//    - No accept: mem_we=0 next cycle, addr/din hold. Back-to-back accepts give 1 word/cycle.
//    - in_last on accept -> DRAIN.
//    - Accept without in_last when word_count==MEM_WORDS-1 (memory now full) -> ERROR; that word is still written.
//    - in_last on the word that fills the memory exactly -> DRAIN, not ERROR.
//    - start is ignored while in LOAD.
//  DRAIN: in_ready=0; one cycle in which the final mem_we pulse lands; then -> RUN.
//  RUN:   cpu_run=1, done=1, in_ready=0, mem_we=0. cpu_run rises exactly 2 cycles after the last accept.
//  ERROR: error=1, cpu_run=0, in_ready=0, mem_we=0; the CPU never runs on a truncated image.
//  Zero-length image is impossible: the first accepted word with in_last=1 is a 1-word image.
//  in_data/in_last are don't-care when in_valid=0. X on in_valid outside LOAD is ignored.
//  Reset mid-LOAD: outputs return to reset values immediately (async).
//    A pending mem_we is dropped; words already written remain in memory.
// TESTING
//  1 Reset, start, 4 words 0x20080005,0x20090003,0x01095020,0x08000003 back-to-back, last on 4th
//    -> mem_we at addr 0..3 in consecutive cycles, checksum=sum mod 2^32, cpu_run rises 2 cycles after 4th accept.
//  2 Same image with in_valid toggling 1,0,0,1,... -> identical addresses/data and checksum;
//    no mem_we on idle cycles; word_count=4.
//  3 MEM_WORDS=8: 8 words, last on 8th -> done=1, error=0.
//    9 words with no last -> error=1 after 8th accept, in_ready=0, cpu_run stays 0, 9th word never accepted.
//  4 rst_n low for 1 cycle after 2 of 4 words accepted -> all outputs at reset values asynchronously;
//    restart with 4 words -> normal load from BASE_ADDR.
//  5 start pulses while in LOAD and RUN -> no effect; in_valid before start -> in_ready=0, nothing written.
//  6 BASE_ADDR=16: 1-word image 0xDEADBEEF with in_last -> single write at addr 16, checksum 0xDEADBEEF,
//    word_count=1, RUN 2 cycles later.

Source files
------------

// File: rtl/mem_loader.sv
// Boot-time program loader: streams words into unified memory over valid/ready,
// keeps the CPU stalled until the image is complete, then hands memory to it.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; loader owns memory, nothing written
// S_LOAD  | accepting words, one registered memory write per accept
// S_DRAIN | final write pulse lands; no more accepts
// S_RUN   | image complete, CPU owns memory (exit by reset only)
// S_ERROR | image overflowed memory, CPU held off (exit by reset only)
module mem_loader #(
    parameter int MEM_WORDS = 1024,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_STEP = 1,
    localparam int CW = $clog2(MEM_WORDS) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    input  logic          in_last,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_din,
    output logic          mem_we,
    output logic          cpu_run,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] word_count,
    output logic [31:0]   checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_RUN,
        S_ERROR
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   mem_full;

    assign accept   = in_valid & in_ready;
    assign mem_full = (word_count == CW'(MEM_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        cpu_run   = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_last)       state_nxt = S_DRAIN;
                    else if (mem_full) state_nxt = S_ERROR;
                end
            end
            S_DRAIN: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                cpu_run = 1'b1;
                done    = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The overflowing word is still written: its pulse lands while in S_ERROR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we     <= 1'b0;
            mem_addr   <= 32'(BASE_ADDR);
            mem_din    <= '0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_addr   <= 32'(BASE_ADDR) + 32'(word_count) * 32'(ADDR_STEP);
                mem_din    <= in_data;
                word_count <= word_count + 1'b1;
                checksum   <= checksum + in_data;
            end else if (state == S_IDLE && start) begin
                word_count <= '0;
                checksum   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: two instances (default, and 8-word memory at base 16)
// driven from a case table, checked against a queue-based model of the expected memory writes.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;

    logic        ready0, ready1, we0, we1, run0, run1, done0, done1, err0, err1;
    logic [31:0] addr0, addr1, din0, din1, cs0, cs1;
    logic [10:0] wc0;
    logic [3:0]  wc1;

    always #5 clk = ~clk;

    mem_loader u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .in_valid(in_valid), .in_ready(ready0),
        .in_data(in_data), .in_last(in_last), .mem_addr(addr0), .mem_din(din0), .mem_we(we0),
        .cpu_run(run0), .done(done0), .error(err0), .word_count(wc0), .checksum(cs0)
    );

    mem_loader #(.MEM_WORDS(8), .BASE_ADDR(16), .ADDR_STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid), .in_ready(ready1),
        .in_data(in_data), .in_last(in_last), .mem_addr(addr1), .mem_din(din1), .mem_we(we1),
        .cpu_run(run1), .done(done1), .error(err1), .word_count(wc1), .checksum(cs1)
    );

    int sel_g = 0;
    logic        s_ready, s_we, s_run, s_done, s_err, o_we;
    logic [31:0] s_addr, s_din, s_cs, s_wc;

    always_comb begin
        s_ready = sel_g != 0 ? ready1 : ready0;
        s_we    = sel_g != 0 ? we1 : we0;
        s_run   = sel_g != 0 ? run1 : run0;
        s_done  = sel_g != 0 ? done1 : done0;
        s_err   = sel_g != 0 ? err1 : err0;
        s_addr  = sel_g != 0 ? addr1 : addr0;
        s_din   = sel_g != 0 ? din1 : din0;
        s_cs    = sel_g != 0 ? cs1 : cs0;
        s_wc    = sel_g != 0 ? 32'(wc1) : 32'(wc0);
        o_we    = sel_g != 0 ? we0 : we1;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run_cyc = -1;
    int stray = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wt_q[$];
    int          acc_q[$];
    logic [31:0] img[32];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (s_we) begin
            wa_q.push_back(s_addr);
            wd_q.push_back(s_din);
            wt_q.push_back(cyc);
        end
        if (o_we) stray++;
        if (s_run && run_cyc < 0) run_cyc = cyc;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", 64'(s_ready), 0);
        chk("rst_mem_we", 64'(s_we), 0);
        chk("rst_mem_addr", 64'(s_addr), sel_g != 0 ? 16 : 0);
        chk("rst_mem_din", 64'(s_din), 0);
        chk("rst_cpu_run", 64'(s_run), 0);
        chk("rst_done", 64'(s_done), 0);
        chk("rst_error", 64'(s_err), 0);
        chk("rst_word_count", 64'(s_wc), 0);
        chk("rst_checksum", 64'(s_cs), 0);
    endtask

    // Asserted mid-cycle so the asynchronous clear is observed before any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_start(input logic v);
        start0 = (sel_g == 0) ? v : 1'b0;
        start1 = (sel_g != 0) ? v : 1'b0;
    endtask

    task automatic load(input int n, input int last, input int mode, input int exp_wc,
                        input bit exp_done, input bit exp_err);
        int idx = 0;
        int guard = 0;
        int mw = (sel_g != 0) ? 8 : 1024;
        int base = (sel_g != 0) ? 16 : 0;
        logic [31:0] sum = '0;
        wa_q.delete(); wd_q.delete(); wt_q.delete(); acc_q.delete();
        run_cyc = -1;
        stray = 0;
        @(posedge clk);
        #1 set_start(1'b1);
        @(posedge clk);
        #1 set_start(1'b0);
        while (idx < n && !s_done && !s_err && guard < 400) begin
            set_start(guard == 2);
            case (mode)
                0: in_valid = 1'b1;
                1: in_valid = (guard % 3) == 0;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (in_valid) begin
                in_data = img[idx];
                in_last = (idx == last);
            end else begin
                in_data = $urandom;
                in_last = 1'($urandom);
            end
            @(negedge clk);
            if (in_valid && s_ready) begin
                acc_q.push_back(cyc);
                idx++;
            end
            @(posedge clk);
            #1 guard++;
        end
        set_start(1'b0);
        if (guard >= 400) chk("load_timeout", 1, 0);
        for (int k = 0; k < 5; k++) begin
            in_valid = (idx < n);
            in_data  = img[idx];
            in_last  = 1'b0;
            @(negedge clk);
            if (in_valid && s_ready) acc_q.push_back(cyc);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;

        for (int i = 0; i < exp_wc; i++) sum += img[i];
        chk("accepts", 64'(acc_q.size()), 64'(exp_wc));
        chk("writes", 64'(wa_q.size()), 64'(exp_wc));
        for (int i = 0; i < wa_q.size() && i < exp_wc && i < acc_q.size(); i++) begin
            chk("wr_addr", 64'(wa_q[i]), 64'(base + i));
            chk("wr_data", 64'(wd_q[i]), 64'(img[i]));
            chk("wr_cycle", 64'(wt_q[i]), 64'(acc_q[i] + 1));
        end
        chk("word_count", 64'(s_wc), 64'(exp_wc));
        chk("checksum", 64'(s_cs), 64'(sum));
        chk("done", 64'(s_done), 64'(exp_done));
        chk("error", 64'(s_err), 64'(exp_err));
        chk("cpu_run", 64'(s_run), 64'(exp_done));
        chk("in_ready_end", 64'(s_ready), 0);
        chk("mem_we_end", 64'(s_we), 0);
        if (exp_done && acc_q.size() > 0)
            chk("run_latency", 64'(run_cyc), 64'(acc_q[acc_q.size()-1] + 2));
        else
            chk("run_never", 64'(run_cyc), 64'(-1));
        if (mw < exp_wc) chk("model_fit", 1, 0);

        // start in a terminal state must change nothing
        @(posedge clk);
        #1 set_start(1'b1);
        @(posedge clk);
        #1 set_start(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("term_done", 64'(s_done), 64'(exp_done));
        chk("term_error", 64'(s_err), 64'(exp_err));
        chk("term_wc", 64'(s_wc), 64'(exp_wc));
        chk("term_writes", 64'(wa_q.size()), 64'(exp_wc));
        chk("stray_writes", 64'(stray), 0);
    endtask

    typedef struct {
        int sel;
        int n;
        int last;
        int mode;
        int img_kind;
        int exp_wc;
        bit exp_done;
        bit exp_err;
    } vec_t;

    vec_t vecs[8];
    logic [31:0] prog[4];

    initial begin
        prog[0] = 32'h20080005; prog[1] = 32'h20090003;
        prog[2] = 32'h01095020; prog[3] = 32'h08000003;
        //          sel  n  last mode kind wc done err
        vecs[0] = '{0,   4,  3,   0,   1,   4,  1,   0};
        vecs[1] = '{0,   4,  3,   1,   1,   4,  1,   0};
        vecs[2] = '{1,   8,  7,   0,   0,   8,  1,   0};
        vecs[3] = '{1,   9,  -1,  0,   0,   8,  0,   1};
        vecs[4] = '{1,   1,  0,   0,   2,   1,  1,   0};
        vecs[5] = '{0,   20, 19,  2,   0,   20, 1,   0};
        vecs[6] = '{1,   12, -1,  2,   0,   8,  0,   1};
        vecs[7] = '{1,   5,  4,   2,   0,   5,  1,   0};

        rst_n = 1'b0;
        #12 rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            sel_g = vecs[v].sel;
            for (int i = 0; i < 32; i++) img[i] = $urandom;
            if (vecs[v].img_kind == 1) for (int i = 0; i < 4; i++) img[i] = prog[i];
            if (vecs[v].img_kind == 2) img[0] = 32'hDEADBEEF;
            do_reset();
            load(vecs[v].n, vecs[v].last, vecs[v].mode, vecs[v].exp_wc,
                 vecs[v].exp_done, vecs[v].exp_err);
        end

        // in_valid before start, then reset with a write pending, then a clean restart
        sel_g = 0;
        for (int i = 0; i < 4; i++) img[i] = prog[i];
        do_reset();
        wa_q.delete();
        stray = 0;
        in_valid = 1'b1;
        in_data  = img[0];
        repeat (3) begin
            @(negedge clk);
            chk("pre_start_ready", 64'(s_ready), 0);
        end
        chk("pre_start_writes", 64'(wa_q.size()), 0);
        @(posedge clk);
        #1 set_start(1'b1);
        @(posedge clk);
        #1 set_start(1'b0);
        in_data = img[0];
        in_last = 1'b0;
        @(posedge clk);
        #1 in_data = img[1];
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("mid_we_pending", 64'(s_we), 1);
        chk("mid_addr", 64'(s_addr), 1);
        chk("mid_wc", 64'(s_wc), 2);
        #1 rst_n = 1'b0;
        #1 check_reset_vals();
        @(posedge clk);
        #1 rst_n = 1'b1;
        load(4, 3, 0, 4, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
